// File: rtl/simple_spi_master.sv
// SPI master: one WIDTH-bit MSB-first exchange per start.
// SCK, nCS and MOSI are all registered; MISO is sampled directly.
`ifndef SIMPLE_SPI_MASTER_SV
`define SIMPLE_SPI_MASTER_SV
module simple_spi_master #(
  parameter int   WIDTH   = 32,
  parameter int   CLK_DIV = 4,
  parameter logic CPOL    = 1'b0
) (
  input  logic             system_clk,
  input  logic             system_rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] value_mosi,
  output logic [WIDTH-1:0] value_miso,
  output logic             busy,
  output logic             done,
  output logic             pin_ncs,
  output logic             pin_clk,
  output logic             pin_mosi,
  input  logic             pin_miso
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCK_HI,
    SCK_LO,
    HOLD,
    GAP
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [DW-1:0]    div;
  logic [BW-1:0]    bits;
  logic [WIDTH-1:0] shreg;
  logic             rx_bit;
  logic             tick;
  logic             rise;

  assign tick = (div == DIV_LAST);
  assign rise = (state_nx == SCK_HI) && (state != SCK_HI);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = SETUP;
      SETUP:   if (tick) state_nx = SCK_HI;
      SCK_HI:  if (tick) state_nx = (bits == BIT_LAST) ? HOLD : SCK_LO;
      SCK_LO:  if (tick) state_nx = SCK_HI;
      HOLD:    if (tick) state_nx = GAP;
      GAP:     if (tick) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge system_clk or negedge system_rst_n) begin
    if (!system_rst_n) begin
      state <= IDLE;
      div   <= '0;
    end else begin
      state <= state_nx;
      div   <= (state == IDLE || tick) ? '0 : div + 1'b1;
    end
  end

  // HOLD is the final low phase; the last received bit shifts in on entry
  always_ff @(posedge system_clk or negedge system_rst_n) begin
    if (!system_rst_n) begin
      bits       <= '0;
      shreg      <= '0;
      rx_bit     <= 1'b0;
      value_miso <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pin_ncs    <= 1'b1;
      pin_clk    <= CPOL;
      pin_mosi   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        shreg    <= value_mosi;
        pin_mosi <= value_mosi[WIDTH-1];
        pin_ncs  <= 1'b0;
        busy     <= 1'b1;
        bits     <= '0;
      end
      if (rise) begin
        pin_clk <= ~CPOL;
        rx_bit  <= pin_miso;
        bits    <= bits + 1'b1;
      end
      if (state == SCK_HI && tick) begin
        pin_clk <= CPOL;
        shreg   <= {shreg[WIDTH-2:0], rx_bit};
        if (state_nx == SCK_LO) pin_mosi <= shreg[WIDTH-2];
      end
      if (state == HOLD && tick) begin
        pin_ncs    <= 1'b1;
        done       <= 1'b1;
        value_miso <= shreg;
        pin_mosi   <= 1'b0;
      end
      if (state == GAP && tick) busy <= 1'b0;
    end
  end

endmodule
`endif

// File: tb/tb_simple_spi_master.sv
// Bench for simple_spi_master: two instances (mode 0 and CPOL=1)
// against a behavioural SPI slave and per-frame timing model.
module tb_simple_spi_master;

  localparam int W  = 8;
  localparam int D0 = 2;
  localparam int D1 = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start [2];
  logic [W-1:0] vmo   [2];
  logic [W-1:0] vmi   [2];
  logic         busy  [2];
  logic         done  [2];
  logic         ncs   [2];
  logic         sck   [2];
  logic         mosi  [2];
  logic         miso  [2];

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  simple_spi_master #(.WIDTH(W), .CLK_DIV(D0), .CPOL(1'b0)) u0 (
    .system_clk(clk), .system_rst_n(rst_n),
    .start(start[0]), .value_mosi(vmo[0]),
    .value_miso(vmi[0]), .busy(busy[0]), .done(done[0]),
    .pin_ncs(ncs[0]), .pin_clk(sck[0]),
    .pin_mosi(mosi[0]), .pin_miso(miso[0])
  );

  simple_spi_master #(.WIDTH(W), .CLK_DIV(D1), .CPOL(1'b1)) u1 (
    .system_clk(clk), .system_rst_n(rst_n),
    .start(start[1]), .value_mosi(vmo[1]),
    .value_miso(vmi[1]), .busy(busy[1]), .done(done[1]),
    .pin_ncs(ncs[1]), .pin_clk(sck[1]),
    .pin_mosi(mosi[1]), .pin_miso(miso[1])
  );

  function automatic int dv(input int i);
    return (i == 1) ? D1 : D0;
  endfunction

  function automatic logic cpol(input int i);
    return (i == 1);
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // behavioural slave: MISO word shifted out MSB first on falling
  // SCK, MOSI captured on rising SCK
  logic [W-1:0] sw   [2];
  logic [W-1:0] srx  [2];
  int           rises[2];
  int           falls[2];
  logic         pncs [2];
  logic         psck [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        rises[i] = 0;
        falls[i] = 0;
        miso[i]  = 1'b0;
        pncs[i]  = 1'b1;
        psck[i]  = 1'b0;
      end else begin
        if (ncs[i] && pncs[i])
          chk("sck_idle", 32'(sck[i]), 32'(cpol(i)));
        if (pncs[i] && !ncs[i]) begin
          rises[i] = 0;
          falls[i] = 0;
          miso[i]  = sw[i][W-1];
        end else if (!ncs[i]) begin
          if ((sck[i] ^ cpol(i)) && !psck[i]) begin
            rises[i]++;
            srx[i] = {srx[i][W-2:0], mosi[i]};
          end
          if (!(sck[i] ^ cpol(i)) && psck[i]) begin
            falls[i]++;
            if (falls[i] < W) miso[i] = sw[i][W-1-falls[i]];
          end
        end
        pncs[i] = ncs[i];
        psck[i] = sck[i] ^ cpol(i);
      end
    end
  end

  // One frame, or two back-to-back frames with start held.
  // Called just after a negedge with the DUT idle.
  task automatic frame(input int i, input int n,
                       input logic [W-1:0] t0, input logic [W-1:0] r0,
                       input logic [W-1:0] t1, input logic [W-1:0] r1,
                       input bit poke);
    int d, t, p, lc, fi, hi;
    d  = dv(i);
    t  = 1 + (2 * W + 1) * d;
    p  = t + d;
    hi = 0;
    sw[i]    = r0;
    vmo[i]   = t0;
    start[i] = 1'b1;
    for (int c = 1; c <= n * p + 3; c++) begin
      @(negedge clk);
      #1;
      fi = (n == 2 && c >= p) ? 1 : 0;
      lc = (fi == 1) ? c - p : c;
      chk("ncs", 32'(ncs[i]), 32'(!(lc >= 1 && lc < t)));
      chk("busy", 32'(busy[i]), 32'(lc >= 1 && lc < p));
      chk("done", 32'(done[i]), 32'(lc == t));
      if (n == 2 && c <= p && ncs[i]) hi++;
      if (lc == t) begin
        chk("value_miso", 32'(vmi[i]), 32'((fi == 1) ? r1 : r0));
        chk("slave_rx", 32'(srx[i]), 32'((fi == 1) ? t1 : t0));
        chk("rises", 32'(rises[i]), 32'(W));
      end
      if (c == 1) begin
        vmo[i] = 8'($urandom);
        if (n == 1) start[i] = 1'b0;
      end
      if (poke && c == 5) start[i] = 1'b1;
      if (poke && c == 6) start[i] = 1'b0;
      if (n == 2 && c == t + 1) begin
        vmo[i] = t1;
        sw[i]  = r1;
      end
      if (n == 2 && c == p + 1) begin
        start[i] = 1'b0;
        vmo[i]   = 8'($urandom);
      end
    end
    if (n == 2) chk("ncs_gap", 32'(hi), 32'(d + 1));
  endtask

  task automatic mid_reset();
    int k;
    sw[0]    = 8'($urandom);
    vmo[0]   = 8'($urandom);
    start[0] = 1'b1;
    k = 0;
    while (k < 200 && rises[0] != 3) begin
      @(negedge clk);
      #1;
      start[0] = 1'b0;
      k++;
    end
    chk("bit3_reached", 32'(rises[0]), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("rst_ncs", 32'(ncs[0]), 32'd1);
    chk("rst_clk", 32'(sck[0]), 32'd0);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_done", 32'(done[0]), 32'd0);
    chk("rst_miso", 32'(vmi[0]), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      chk("no_done", 32'(done[0]), 32'd0);
      chk("idle_ncs", 32'(ncs[0]), 32'd1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0;
      vmo[i]   = '0;
      sw[i]    = '0;
      srx[i]   = '0;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset_ncs", 32'(ncs[i]), 32'd1);
      chk("reset_clk", 32'(sck[i]), 32'(cpol(i)));
      chk("reset_mosi", 32'(mosi[i]), 32'd0);
      chk("reset_busy", 32'(busy[i]), 32'd0);
      chk("reset_done", 32'(done[i]), 32'd0);
      chk("reset_miso", 32'(vmi[i]), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    frame(0, 1, 8'hA5, 8'hA5, 8'h00, 8'h00, 1'b0);
    frame(1, 1, 8'h3C, 8'hC3, 8'h00, 8'h00, 1'b0);
    frame(0, 1, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b0);
    frame(1, 1, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0);
    for (int r = 0; r < 8; r++)
      frame(r % 2, 1, 8'($urandom), 8'($urandom),
            8'h00, 8'h00, (r == 2 || r == 5));
    frame(0, 2, 8'($urandom), 8'($urandom),
          8'($urandom), 8'($urandom), 1'b0);
    frame(1, 2, 8'($urandom), 8'($urandom),
          8'($urandom), 8'($urandom), 1'b0);
    mid_reset();
    frame(0, 1, 8'h5A, 8'h96, 8'h00, 8'h00, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
